uart_rx_fifo: RTL and testbench



---
 rtl/uart_defs.sv | 29 ++
 rtl/uart_rx_fifo_sync_fifo_fwft.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// constants and the layout of one received-byte FIFO entry.
package uart_defs;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   localparam int ENT_PE = 8;
   localparam int ENT_FE = 9;
   localparam int ENT_BI = 10;
   localparam int ENT_W  = 11;

   function automatic logic [ENT_W-1:0] pack_entry(input logic [7:0] d,
                                                    input logic pe,
                                                    input logic fe,
                                                    input logic bi);
      return {bi, fe, pe, d};
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo_fwft.sv
// Fall-through synchronous FIFO: the head entry is presented combinationally,
// a push while full without a simultaneous pop is dropped and flagged.
module sync_fifo_fwft #(
   parameter int W  = 11,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_din,
   input  logic          i_pop,
   output logic [W-1:0]  o_dout,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_count,
   output logic          o_drop
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_count   = r_count;
   assign w_do_pop  = i_pop & ~o_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_drop    = i_push & ~w_do_push;
   assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 8 data bits, optional parity, one stop
// bit, with each byte and its error flags queued in a fall-through FIFO.
module uart_rx_fifo
   import uart_defs::*;
#(
   parameter int FIFO_AW = 4,
   parameter int DIV_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic [DIV_W-1:0] divisor,
   input  logic             parity_en,
   input  logic             parity_even,
   input  logic             rd,
   input  logic             lsr_rd,
   output logic [7:0]       rx_dat_o,
   output logic             rx_pe_o,
   output logic             rx_fe_o,
   output logic             rx_bi_o,
   output logic             rx_empty_o,
   output logic [FIFO_AW:0] rx_count_o,
   output logic             overrun_o,
   output rx_state_e        dbg_state_o
);

   logic [DIV_W-1:0] r_tick_cnt;
   logic [DIV_W-1:0] w_reload;
   logic             w_tick;
   logic             r_rx_meta;
   logic             r_rx_s;
   rx_state_e        r_state;
   logic [3:0]       r_smp_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_data;
   logic             r_pbit;
   logic             r_par_en;
   logic             r_par_even;
   logic             r_push;
   logic [ENT_W-1:0] r_push_ent;
   logic             w_pe;
   logic             w_bi;
   logic             w_bit_end;
   logic             w_mid_start;
   logic [ENT_W-1:0] w_head;
   logic             w_full;
   logic             w_drop;

   assign w_reload = (divisor == '0) ? '0 : divisor - 1'b1;
   assign w_tick   = (r_tick_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= w_reload;
      end else begin
         r_tick_cnt <= r_tick_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   assign w_mid_start = w_tick & (r_smp_cnt == 4'(MID_SAMPLE - 1));
   assign w_bit_end   = w_tick & (r_smp_cnt == 4'(OVERSAMPLE - 1));
   // Parity error when the ones-count of data plus parity bit has the wrong sense.
   assign w_pe = r_par_en & (^{r_data, r_pbit} ^ ~r_par_even);
   assign w_bi = ~r_rx_s & (r_data == 8'h00) & (~r_pbit | ~r_par_en);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_smp_cnt  <= '0;
         r_bit_idx  <= '0;
         r_data     <= '0;
         r_pbit     <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_even <= 1'b0;
         r_push     <= 1'b0;
         r_push_ent <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_tick && !w_bit_end && r_state inside {ST_DATA, ST_PARITY, ST_STOP}) begin
            r_smp_cnt <= r_smp_cnt + 4'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (!r_rx_s) begin
                  r_smp_cnt  <= '0;
                  r_pbit     <= 1'b0;
                  r_par_en   <= parity_en;
                  r_par_even <= parity_even;
                  r_state    <= ST_START;
               end
            end
            ST_START: begin
               if (w_mid_start) begin
                  r_smp_cnt <= '0;
                  r_bit_idx <= '0;
                  r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
               end else if (w_tick) begin
                  r_smp_cnt <= r_smp_cnt + 4'd1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_smp_cnt <= '0;
                  r_data    <= {r_rx_s, r_data[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= r_par_en ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_smp_cnt <= '0;
                  r_pbit    <= r_rx_s;
                  r_state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  r_smp_cnt  <= '0;
                  r_push     <= 1'b1;
                  r_push_ent <= pack_entry(r_data, w_pe, ~r_rx_s, w_bi);
                  r_state    <= r_rx_s ? ST_IDLE : ST_WAIT_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (r_rx_s) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   sync_fifo_fwft #(
      .W  (ENT_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_push),
      .i_din   (r_push_ent),
      .i_pop   (rd),
      .o_dout  (w_head),
      .o_empty (rx_empty_o),
      .o_full  (w_full),
      .o_count (rx_count_o),
      .o_drop  (w_drop)
   );

   // Set has priority so an overrun coinciding with an LSR read is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun_o <= 1'b0;
      end else if (w_drop) begin
         overrun_o <= 1'b1;
      end else if (lsr_rd) begin
         overrun_o <= 1'b0;
      end
   end

   assign rx_dat_o    = w_head[7:0];
   assign rx_pe_o     = w_head[ENT_PE];
   assign rx_fe_o     = w_head[ENT_FE];
   assign rx_bi_o     = w_head[ENT_BI];
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames are driven on rx, the
// expected FIFO entries are queued from a frame-level model and checked on pop.
module tb_uart_rx_fifo;
   import uart_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx = 1'b1;
   logic [15:0] divisor = 16'd1;
   logic        parity_en = 1'b0;
   logic        parity_even = 1'b0;
   logic        rd = 1'b0;
   logic        lsr_rd = 1'b0;
   logic [7:0]  rx_dat_o;
   logic        rx_pe_o;
   logic        rx_fe_o;
   logic        rx_bi_o;
   logic        rx_empty_o;
   logic [4:0]  rx_count_o;
   logic        overrun_o;
   rx_state_e   dbg_state_o;

   int checks = 0;
   int failures = 0;
   logic [10:0] exp_q[$];
   int m_count = 0;
   bit m_overrun = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.FIFO_AW(4), .DIV_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .divisor     (divisor),
      .parity_en   (parity_en),
      .parity_even (parity_even),
      .rd          (rd),
      .lsr_rd      (lsr_rd),
      .rx_dat_o    (rx_dat_o),
      .rx_pe_o     (rx_pe_o),
      .rx_fe_o     (rx_fe_o),
      .rx_bi_o     (rx_bi_o),
      .rx_empty_o  (rx_empty_o),
      .rx_count_o  (rx_count_o),
      .overrun_o   (overrun_o),
      .dbg_state_o (dbg_state_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: entry = {bi, fe, pe, data}.
   function automatic logic [10:0] model_entry(input logic [7:0] d, input bit pen,
                                               input bit peven, input bit pbit, input bit stop);
      int ones;
      bit pe, fe, bi;
      ones = $countones(d) + (pbit ? 1 : 0);
      pe = pen && (peven ? (ones % 2 == 1) : (ones % 2 == 0));
      fe = !stop;
      bi = fe && (d == 8'h00) && (!pen || !pbit);
      return {bi, fe, pe, d};
   endfunction

   task automatic model_push(input logic [10:0] e);
      if (m_count < 16) begin
         exp_q.push_back(e);
         m_count++;
      end else begin
         m_overrun = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stop);
      int cpb;
      cpb = 16 * ((divisor == 16'd0) ? 1 : int'(divisor));
      @(negedge clk);
      rx = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (cpb) @(negedge clk);
      end
      if (pen) begin
         rx = pbit;
         repeat (cpb) @(negedge clk);
      end
      rx = stop;
      repeat (cpb) @(negedge clk);
      rx = 1'b1;
      repeat (cpb) @(negedge clk);
   endtask

   task automatic pop_one();
      int n;
      n = 0;
      while (rx_empty_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (rx_empty_o) begin
         checks++;
         failures++;
         $display("FAIL pop_timeout: FIFO still empty after %0d cycles", n);
      end else begin
         @(posedge clk) #1 rd = 1'b1;
         @(posedge clk) #1 rd = 1'b0;
         m_count--;
      end
      @(negedge clk);
   endtask

   task automatic set_div(input logic [15:0] d);
      @(negedge clk);
      divisor = d;
      repeat (64) @(negedge clk);
   endtask

   // Monitor: every accepted pop is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (rst && rd && !rx_empty_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_entry: got 0x%0h with no entry expected",
                     {rx_bi_o, rx_fe_o, rx_pe_o, rx_dat_o});
         end else begin
            check("head_entry", 32'({rx_bi_o, rx_fe_o, rx_pe_o, rx_dat_o}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      bit pen, peven, pbit, stop, seen;
      int n;

      #12;
      check("rst_empty", 32'(rx_empty_o), 32'd1);
      check("rst_count", 32'(rx_count_o), 32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_head", 32'({rx_bi_o, rx_fe_o, rx_pe_o, rx_dat_o}), 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);

      // 0x55 8N1 at divisor 1
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      model_push(model_entry(8'h55, 1'b0, 1'b0, 1'b0, 1'b1));
      check("basic_empty", 32'(rx_empty_o), 32'd0);
      check("basic_count", 32'(rx_count_o), 32'(m_count));
      pop_one();
      check("basic_empty_after", 32'(rx_empty_o), 32'd1);
      check("basic_count_after", 32'(rx_count_o), 32'd0);
      check("empty_head_zero", 32'({rx_bi_o, rx_fe_o, rx_pe_o, rx_dat_o}), 32'd0);

      // rd while empty is ignored
      @(posedge clk) #1 rd = 1'b1;
      @(posedge clk) #1 rd = 1'b0;
      @(negedge clk);
      check("rd_empty_count", 32'(rx_count_o), 32'd0);

      // parity cases at divisor 3
      set_div(16'd3);
      parity_en = 1'b1;
      parity_even = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      model_push(model_entry(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1));
      pop_one();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      model_push(model_entry(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1));
      pop_one();
      parity_even = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      model_push(model_entry(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1));
      pop_one();

      // glitch shorter than half a bit
      parity_en = 1'b0;
      set_div(16'd1);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_state", 32'(dbg_state_o), 32'(ST_IDLE));
      check("glitch_count", 32'(rx_count_o), 32'd0);

      // break held for three frame times, then a normal frame
      rx = 1'b0;
      repeat (30 * 16) @(negedge clk);
      rx = 1'b1;
      repeat (48) @(negedge clk);
      model_push(model_entry(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      check("break_count", 32'(rx_count_o), 32'(m_count));
      pop_one();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      model_push(model_entry(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1));
      pop_one();

      // randomised frames
      for (int k = 0; k < 20; k++) begin
         set_div(16'($urandom_range(0, 3)));
         pen = 1'($urandom_range(0, 1));
         peven = 1'($urandom_range(0, 1));
         pbit = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 7) != 0);
         d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         parity_en = pen;
         parity_even = peven;
         send_frame(d, pen, pbit, stop);
         model_push(model_entry(d, pen, peven, pbit, stop));
         pop_one();
      end
      check("random_count", 32'(rx_count_o), 32'd0);

      // overflow: 17 frames without reads
      set_div(16'd1);
      parity_en = 1'b0;
      for (int k = 0; k < 17; k++) begin
         d = 8'($urandom);
         send_frame(d, 1'b0, 1'b0, 1'b1);
         model_push(model_entry(d, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      check("ovf_count", 32'(rx_count_o), 32'(m_count));
      check("ovf_overrun", 32'(overrun_o), 32'(m_overrun));
      lsr_rd = 1'b1;
      @(negedge clk);
      lsr_rd = 1'b0;
      m_overrun = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 32'(overrun_o), 32'(m_overrun));

      // push and pop in the same cycle while full
      d = 8'($urandom);
      exp_q.push_back(model_entry(d, 1'b0, 1'b0, 1'b0, 1'b1));
      seen = 1'b0;
      fork
         send_frame(d, 1'b0, 1'b0, 1'b1);
         begin
            n = 0;
            while (dbg_state_o != ST_STOP && n < 4000) begin
               @(posedge clk) #1;
               n++;
            end
            while (dbg_state_o == ST_STOP && n < 4000) begin
               @(posedge clk) #1;
               n++;
            end
            if (n < 4000) begin
               seen = 1'b1;
               rd = 1'b1;
               @(posedge clk) #1 rd = 1'b0;
            end
         end
      join
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL stop_watch_timeout: stop state not observed");
      end
      check("full_pushpop_count", 32'(rx_count_o), 32'd16);
      check("full_pushpop_overrun", 32'(overrun_o), 32'd0);
      repeat (16) pop_one();
      check("drain_count", 32'(rx_count_o), 32'd0);

      // reset in the middle of data bit 4 with an entry already queued
      send_frame(8'h77, 1'b0, 1'b0, 1'b1);
      model_push(model_entry(8'h77, 1'b0, 1'b0, 1'b0, 1'b1));
      lsr_rd = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      d = 8'h81;
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (16) @(negedge clk);
      end
      rx = d[4];
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_empty", 32'(rx_empty_o), 32'd1);
      check("mid_rst_count", 32'(rx_count_o), 32'd0);
      check("mid_rst_head", 32'({rx_bi_o, rx_fe_o, rx_pe_o, rx_dat_o}), 32'd0);
      check("mid_rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
      exp_q.delete();
      m_count = 0;
      m_overrun = 1'b0;
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (32) @(negedge clk);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      model_push(model_entry(8'h81, 1'b0, 1'b0, 1'b0, 1'b1));
      check("post_rst_count", 32'(rx_count_o), 32'd1);
      pop_one();

      repeat (4) @(negedge clk);
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
